// File: rtl/lsu_dmem_port.sv
// Load/store unit on the word-only data RAM: aligns/extends sub-word loads, does SB/SH as read-modify-write.
// Latency err 1, SW 2, loads 3, SB/SH 4; one request in flight (req_ready low while busy), responses cannot be stalled.
module lsu_dmem_port #(
   parameter int WORD_LEN = 32,
   parameter int DEPTH    = 4096
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_wen,
   input  logic [2:0]          req_funct3,
   input  logic [WORD_LEN-1:0] req_addr,
   input  logic [WORD_LEN-1:0] req_wdata,
   output logic                resp_valid,
   output logic [WORD_LEN-1:0] resp_rdata,
   output logic                resp_err,
   output logic [WORD_LEN-1:0] mem_addr_d,
   input  logic [WORD_LEN-1:0] mem_rdata,
   output logic                mem_wen,
   output logic [WORD_LEN-1:0] mem_wdata
);

   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DATA, WR, RESP} state_t;

   typedef struct packed {
      logic       wen;
      logic [2:0] funct3;
   } op_t;

   state_t              state;
   op_t                 op_q;
   logic [WORD_LEN-1:0] addr_q;
   logic [WORD_LEN-1:0] wdata_q;

   logic                f3_ok;
   logic                align_ok;
   logic                range_ok;
   logic                req_err;

   logic [4:0]          lane_sh;
   logic [7:0]          ld_byte;
   logic [15:0]         ld_half;
   logic [WORD_LEN-1:0] ld_val;
   logic [WORD_LEN-1:0] st_mask;
   logic [WORD_LEN-1:0] st_merged;

   // Request legality: funct3 class, natural alignment, and word index inside the RAM.
   always_comb begin
      f3_ok    = 1'b0;
      align_ok = 1'b0;
      case (req_funct3)
         3'b000, 3'b100: begin
            f3_ok    = !(req_wen && req_funct3[2]);
            align_ok = 1'b1;
         end
         3'b001, 3'b101: begin
            f3_ok    = !(req_wen && req_funct3[2]);
            align_ok = !req_addr[0];
         end
         3'b010: begin
            f3_ok    = 1'b1;
            align_ok = (req_addr[1:0] == 2'b00);
         end
         default: begin
            f3_ok    = 1'b0;
            align_ok = 1'b0;
         end
      endcase
      range_ok = (req_addr >> 2) < WORD_LEN'(DEPTH);
      req_err  = !(f3_ok && align_ok && range_ok);
   end

   // Lane extraction for loads and lane merge for SB/SH, both off the returning RAM word.
   always_comb begin
      lane_sh   = {addr_q[1:0], 3'b000};
      ld_byte   = 8'(mem_rdata >> lane_sh);
      ld_half   = 16'(mem_rdata >> {addr_q[1], 4'b0000});
      ld_val    = mem_rdata;
      case (op_q.funct3)
         3'b000:  ld_val = {{(WORD_LEN-8){ld_byte[7]}}, ld_byte};
         3'b001:  ld_val = {{(WORD_LEN-16){ld_half[15]}}, ld_half};
         3'b100:  ld_val = WORD_LEN'(ld_byte);
         3'b101:  ld_val = WORD_LEN'(ld_half);
         default: ld_val = mem_rdata;
      endcase
      st_mask   = (op_q.funct3[0] ? WORD_LEN'(16'hFFFF) : WORD_LEN'(8'hFF)) << lane_sh;
      st_merged = (mem_rdata & ~st_mask) | ((wdata_q << lane_sh) & st_mask);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         op_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         req_ready  <= 1'b1;
         mem_wen    <= 1'b0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
      end else begin
         resp_valid <= 1'b0;
         mem_wen    <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q.wen    <= req_wen;
                  op_q.funct3 <= req_funct3;
                  addr_q      <= req_addr;
                  wdata_q     <= req_wdata;
                  resp_rdata  <= '0;
                  resp_err    <= req_err;
                  req_ready   <= 1'b0;
                  if (req_err) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                  end else if (req_wen && req_funct3 == 3'b010) begin
                     state   <= WR;
                     mem_wen <= 1'b1;
                  end else begin
                     state <= RD_ISSUE;
                  end
               end
            end
            RD_ISSUE: state <= RD_DATA;
            RD_DATA: begin
               if (op_q.wen) begin
                  wdata_q <= st_merged;
                  mem_wen <= 1'b1;
                  state   <= WR;
               end else begin
                  resp_rdata <= ld_val;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end
            end
            WR: begin
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign mem_addr_d = {addr_q[WORD_LEN-1:2], 2'b00};
   assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Bench for lsu_dmem_port: plays the one-cycle-latency data RAM and checks responses against a byte-addressed model.
module tb_lsu_dmem_port;
   localparam int DEPTH = 4096;

   typedef struct {
      int          lat;
      logic [31:0] rdata;
      logic        err;
      int          wr_cnt;
      int          wr_cyc;
      logic [31:0] wr_addr;
      logic [31:0] wr_dat;
      logic [31:0] addr_c1;
      logic        ready_c1;
      logic        ready_resp;
      int          wait_cyc;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wen = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr_d;
   logic [31:0] mem_rdata;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic        load_ram = 1'b0;

   logic [31:0] ram   [0:DEPTH-1];
   logic [7:0]  mbyte [0:4*DEPTH-1];
   int          vectors = 0;
   int          miscompares = 0;

   lsu_dmem_port #(.WORD_LEN(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr_d(mem_addr_d), .mem_rdata(mem_rdata), .mem_wen(mem_wen), .mem_wdata(mem_wdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (load_ram) begin
         for (int i = 0; i < DEPTH; i++)
            ram[i] <= {mbyte[4*i+3], mbyte[4*i+2], mbyte[4*i+1], mbyte[4*i]};
      end else if (mem_wen) begin
         ram[mem_addr_d[13:2]] <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr_d[13:2]];
   end

   // Reference: byte-addressed memory, RV32I access rules, fixed latency per access class.
   function automatic void model_txn(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                                     input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                                     output logic err, output logic wr, output logic [31:0] wword);
      int          size;
      logic        legal;
      logic [31:0] v;
      logic [31:0] base;
      size  = 1 << f3[1:0];
      legal = wen ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      err   = !legal || (addr % size) != 0 || (addr / 4) >= DEPTH;
      rdata = '0;
      wr    = 1'b0;
      wword = '0;
      lat   = 1;
      if (!err && !wen) begin
         v = '0;
         for (int i = 0; i < size; i++) v = v | (32'(mbyte[addr + i]) << (8 * i));
         if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 1);
         rdata = v;
         lat   = 3;
      end else if (!err) begin
         for (int i = 0; i < size; i++) mbyte[addr + i] = wdata[8*i +: 8];
         base  = addr & ~32'd3;
         wword = {mbyte[base+3], mbyte[base+2], mbyte[base+1], mbyte[base]};
         wr    = 1'b1;
         lat   = (size == 4) ? 2 : 4;
      end
   endfunction

   task automatic issue(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit noise, output obs_t o);
      o.lat = -1; o.rdata = '0; o.err = 1'b0; o.wr_cnt = 0; o.wr_cyc = -1; o.wr_addr = '0;
      o.wr_dat = '0; o.addr_c1 = '0; o.ready_c1 = 1'b1; o.ready_resp = 1'b1; o.wait_cyc = 0;
      @(negedge clk);
      while (!req_ready && o.wait_cyc < 20) begin
         @(negedge clk);
         o.wait_cyc++;
      end
      req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) begin o.addr_c1 = mem_addr_d; o.ready_c1 = req_ready; end
         if (mem_wen) begin
            o.wr_cnt++; o.wr_cyc = k; o.wr_addr = mem_addr_d; o.wr_dat = mem_wdata;
         end
         if (resp_valid) begin
            o.lat = k; o.rdata = resp_rdata; o.err = resp_err; o.ready_resp = req_ready;
            req_valid = 1'b0;
            break;
         end
         if (noise) begin
            req_valid = 1'b1; req_wen = 1'($urandom); req_funct3 = 3'($urandom);
            req_addr = 32'($urandom_range(0, 63)); req_wdata = $urandom;
         end
      end
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
      vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
      vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL rst_resp_err got %b want 0", resp_err); end
      vectors++; if (resp_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_resp_rdata got %h want 0", resp_rdata); end
      vectors++; if (mem_wen !== 1'b0) begin miscompares++; $display("FAIL rst_mem_wen got %b want 0", mem_wen); end
      vectors++; if (mem_addr_d !== 32'h0) begin miscompares++; $display("FAIL rst_mem_addr got %h want 0", mem_addr_d); end
      vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
      load_ram = 1'b1;
      @(posedge clk);
      #1 load_ram = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_subword_loads();
      logic [2:0]  f3s  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
      logic [31:0] adrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
      logic [31:0] exps [4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h0000AABB};
      obs_t o;
      for (int i = 0; i < 4; i++) begin
         issue(1'b0, f3s[i], adrs[i], 32'h0, 1'b0, o);
         vectors++; if (o.lat !== 3) begin miscompares++; $display("FAIL load%0d_lat got %0d want 3", i, o.lat); end
         vectors++; if (o.rdata !== exps[i]) begin miscompares++; $display("FAIL load%0d_data got %h want %h", i, o.rdata, exps[i]); end
         vectors++; if (o.err !== 1'b0) begin miscompares++; $display("FAIL load%0d_err got %b want 0", i, o.err); end
         vectors++; if (o.wr_cnt !== 0) begin miscompares++; $display("FAIL load%0d_wen got %0d writes want 0", i, o.wr_cnt); end
      end
   endtask

   task automatic test_sb_rmw();
      obs_t o;
      int lat; logic [31:0] rd; logic er, wr; logic [31:0] ww;
      model_txn(1'b1, 3'd0, 32'h11, 32'h12345677, lat, rd, er, wr, ww);
      issue(1'b1, 3'd0, 32'h11, 32'h12345677, 1'b0, o);
      vectors++; if (o.addr_c1 !== 32'h10 || o.ready_c1 !== 1'b0) begin miscompares++; $display("FAIL sb_issue got addr %h ready %b want 10/0", o.addr_c1, o.ready_c1); end
      vectors++; if (o.wr_cnt !== 1 || o.wr_cyc !== 3) begin miscompares++; $display("FAIL sb_wen got %0d writes at cycle %0d want 1 at 3", o.wr_cnt, o.wr_cyc); end
      vectors++; if (o.wr_dat !== 32'h889977BB) begin miscompares++; $display("FAIL sb_wdata got %h want 889977bb", o.wr_dat); end
      vectors++; if (o.lat !== 4) begin miscompares++; $display("FAIL sb_lat got %0d want 4", o.lat); end
      issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, o);
      vectors++; if (o.rdata !== 32'h889977BB) begin miscompares++; $display("FAIL sb_readback got %h want 889977bb", o.rdata); end
   endtask

   task automatic test_sw_sh();
      obs_t o;
      int lat; logic [31:0] rd; logic er, wr; logic [31:0] ww;
      model_txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, lat, rd, er, wr, ww);
      issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, o);
      vectors++; if (o.wr_cyc !== 1 || o.wr_addr !== 32'h10) begin miscompares++; $display("FAIL sw_wen got cycle %0d addr %h want 1/10", o.wr_cyc, o.wr_addr); end
      vectors++; if (o.lat !== 2) begin miscompares++; $display("FAIL sw_lat got %0d want 2", o.lat); end
      model_txn(1'b1, 3'd1, 32'h12, 32'h0000CAFE, lat, rd, er, wr, ww);
      issue(1'b1, 3'd1, 32'h12, 32'h0000CAFE, 1'b0, o);
      vectors++; if (o.wr_dat !== 32'hCAFEBEEF) begin miscompares++; $display("FAIL sh_wdata got %h want cafebeef", o.wr_dat); end
      issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, o);
      vectors++; if (o.rdata !== 32'hCAFEBEEF) begin miscompares++; $display("FAIL sh_readback got %h want cafebeef", o.rdata); end
   endtask

   task automatic test_errors();
      logic        wens [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [2:0]  f3s  [4] = '{3'd2, 3'd1, 3'd3, 3'd2};
      logic [31:0] adrs [4] = '{32'h12, 32'h01, 32'h10, 32'h4000};
      obs_t o;
      for (int i = 0; i < 4; i++) begin
         issue(wens[i], f3s[i], adrs[i], 32'hA5A5A5A5, 1'b0, o);
         vectors++; if (o.lat !== 1 || o.err !== 1'b1) begin miscompares++; $display("FAIL err%0d_resp got lat %0d err %b want 1/1", i, o.lat, o.err); end
         vectors++; if (o.rdata !== 32'h0) begin miscompares++; $display("FAIL err%0d_rdata got %h want 0", i, o.rdata); end
         vectors++; if (o.wr_cnt !== 0) begin miscompares++; $display("FAIL err%0d_wen got %0d writes want 0", i, o.wr_cnt); end
      end
   endtask

   task automatic test_reset_mid_rmw();
      obs_t        o;
      logic [31:0] keep;
      logic        seen;
      keep = {mbyte[35], mbyte[34], mbyte[33], mbyte[32]};
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'd0; req_addr = 32'h21; req_wdata = ~keep;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if (mem_wen !== 1'b1) begin miscompares++; $display("FAIL mid_wr_state got mem_wen %b want 1", mem_wen); end
      rst = 1'b1;
      #1;
      vectors++; if (mem_wen !== 1'b0) begin miscompares++; $display("FAIL mid_wen_drop got %b want 0", mem_wen); end
      @(posedge clk);
      #1;
      vectors++; if (ram[8] !== keep) begin miscompares++; $display("FAIL mid_ram_word got %h want %h", ram[8], keep); end
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL mid_no_resp got resp_valid seen %b want 0", seen); end
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready got %b want 1", req_ready); end
      issue(1'b0, 3'd2, 32'h20, 32'h0, 1'b0, o);
      vectors++; if (o.rdata !== keep || o.lat !== 3) begin miscompares++; $display("FAIL mid_lw got %h lat %0d want %h lat 3", o.rdata, o.lat, keep); end
      issue(1'b0, 3'd2, 32'h20, 32'h0, 1'b0, o);
      vectors++; if (o.wait_cyc !== 0 || o.ready_resp !== 1'b0) begin miscompares++; $display("FAIL b2b_accept got wait %0d ready_in_resp %b want 0/0", o.wait_cyc, o.ready_resp); end
   endtask

   task automatic test_random();
      logic [2:0]  ld_ok [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      obs_t        o;
      logic        wen, er, wr;
      logic [2:0]  f3;
      logic [31:0] addr, wdata, rd, ww;
      int          lat;
      bit          noise;
      for (int n = 0; n < 200; n++) begin
         wen = 1'($urandom);
         if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
         else f3 = wen ? 3'($urandom_range(0, 2)) : ld_ok[$urandom_range(0, 4)];
         if ($urandom_range(0, 15) == 0) addr = 32'h4000 + ($urandom & 32'h0FFF_FFFF);
         else addr = 32'($urandom_range(0, 31));
         wdata = $urandom;
         noise = 1'($urandom);
         model_txn(wen, f3, addr, wdata, lat, rd, er, wr, ww);
         issue(wen, f3, addr, wdata, noise, o);
         vectors++; if (o.lat !== lat || o.err !== er) begin miscompares++; $display("FAIL rnd%0d_resp got lat %0d err %b want %0d/%b", n, o.lat, o.err, lat, er); end
         vectors++; if (o.rdata !== rd) begin miscompares++; $display("FAIL rnd%0d_rdata got %h want %h", n, o.rdata, rd); end
         vectors++; if (o.wr_cnt !== int'(wr)) begin miscompares++; $display("FAIL rnd%0d_wcnt got %0d want %0d", n, o.wr_cnt, wr); end
         if (wr) begin
            vectors++; if (o.wr_dat !== ww || o.wr_addr !== (addr & ~32'd3)) begin miscompares++; $display("FAIL rnd%0d_write got %h@%h want %h@%h", n, o.wr_dat, o.wr_addr, ww, addr & ~32'd3); end
         end
         vectors++; if (o.wait_cyc !== 0 || o.ready_resp !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_handshake got wait %0d ready_in_resp %b want 0/0", n, o.wait_cyc, o.ready_resp); end
      end
   endtask

   initial begin
      for (int i = 0; i < 4 * DEPTH; i++) mbyte[i] = 8'($urandom);
      mbyte[16] = 8'hBB; mbyte[17] = 8'hAA; mbyte[18] = 8'h99; mbyte[19] = 8'h88;
      test_reset();
      test_subword_loads();
      test_sb_rmw();
      test_sw_sh();
      test_errors();
      test_reset_mid_rmw();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got no completion want summary by 400000");
      $fatal(1, "watchdog expired");
   end

endmodule
